// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO datapath/producer/consumer side
// (master) and the fifo_ctrl sequencing controller (slave).
interface fifo_ctrl_if #(
    parameter int CW = 8
);
    logic          wr_req;
    logic          rd_req;
    logic          full;
    logic          empty;
    logic          ld1;
    logic          ld2;
    logic          ld3;
    logic          wr_ack;
    logic          rd_valid;
    logic          busy;
    logic          overflow;
    logic          underflow;
    logic [CW-1:0] drop_cnt;

    modport master (
        output wr_req,
        output rd_req,
        output full,
        output empty,
        input  ld1,
        input  ld2,
        input  ld3,
        input  wr_ack,
        input  rd_valid,
        input  busy,
        input  overflow,
        input  underflow,
        input  drop_cnt
    );

    modport slave (
        input  wr_req,
        input  rd_req,
        input  full,
        input  empty,
        output ld1,
        output ld2,
        output ld3,
        output wr_ack,
        output rd_valid,
        output busy,
        output overflow,
        output underflow,
        output drop_cnt
    );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO sequencing controller: arbitrates write/read requests against the
// datapath full/empty flags, issues one-cycle load strobes, and keeps sticky
// refusal flags plus a saturating count of refused requests.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_INIT    | clear/init strobe (ld1) to buffer and pointers
// S_IDLE    | evaluate requests, count refusals, pick next operation
// S_WRITE   | write-pointer load (ld2) and write acknowledge
// S_READ    | read-pointer load (ld3)
// S_RD_DONE | datapath output valid (rd_valid)
module fifo_ctrl #(
    parameter int CW = 8
) (
    input  logic       clk,
    input  logic       rst,
    fifo_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_WRITE   = 3'd2,
        S_READ    = 3'd3,
        S_RD_DONE = 3'd4
    } state_t;

    localparam logic [CW+1:0] CNT_MAX = {2'b00, {CW{1'b1}}};

    state_t        state;
    state_t        state_nxt;
    logic          last_served;      // 0: write served last, 1: read served last
    logic          last_served_nxt;
    logic          wr_ok;
    logic          rd_ok;
    logic          wr_refuse;
    logic          rd_refuse;
    logic          overflow_flag;
    logic          underflow_flag;
    logic [CW-1:0] drop_count;
    logic [CW+1:0] drop_sum;
    logic [CW-1:0] drop_count_nxt;

    // State register and arbitration history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_INIT;
            last_served <= 1'b1;
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
        end
    end

    // Next-state selection, fair arbitration and refusal detection.
    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        wr_refuse       = 1'b0;
        rd_refuse       = 1'b0;
        wr_ok           = bus.wr_req & ~bus.full;
        rd_ok           = bus.rd_req & ~bus.empty;
        case (state)
            S_INIT: begin
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                wr_refuse = bus.wr_req & bus.full;
                rd_refuse = bus.rd_req & bus.empty;
                // When both are eligible, serve whichever type did not go last.
                if (wr_ok && (!rd_ok || last_served)) begin
                    state_nxt       = S_WRITE;
                    last_served_nxt = 1'b0;
                end else if (rd_ok) begin
                    state_nxt       = S_READ;
                    last_served_nxt = 1'b1;
                end
            end
            S_WRITE: begin
                state_nxt = S_IDLE;
            end
            S_READ: begin
                state_nxt = S_RD_DONE;
            end
            S_RD_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Saturating add of this cycle's refusals (zero, one or two).
    always_comb begin
        drop_sum = {2'b00, drop_count}
                 + {{(CW+1){1'b0}}, wr_refuse}
                 + {{(CW+1){1'b0}}, rd_refuse};
        if (drop_sum > CNT_MAX) begin
            drop_count_nxt = CNT_MAX[CW-1:0];
        end else begin
            drop_count_nxt = drop_sum[CW-1:0];
        end
    end

    // Sticky refusal flags and refused-request counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            drop_count     <= '0;
        end else begin
            overflow_flag  <= overflow_flag | wr_refuse;
            underflow_flag <= underflow_flag | rd_refuse;
            drop_count     <= drop_count_nxt;
        end
    end

    // Strobes come only from the state register; the reset term silences them
    // in any cycle whose closing edge resets, which also aborts a pending
    // rd_valid and keeps ld1 low until reset is released.
    assign bus.ld1       = (state == S_INIT)    & ~rst;
    assign bus.ld2       = (state == S_WRITE)   & ~rst;
    assign bus.ld3       = (state == S_READ)    & ~rst;
    assign bus.wr_ack    = (state == S_WRITE)   & ~rst;
    assign bus.rd_valid  = (state == S_RD_DONE) & ~rst;
    assign bus.busy      = (state != S_IDLE)    | rst;
    assign bus.overflow  = overflow_flag;
    assign bus.underflow = underflow_flag;
    assign bus.drop_cnt  = drop_count;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: two instances (CW=8 and CW=2) share one stimulus
// stream; a schedule-queue model predicts every output each cycle, and a few
// directed scenarios pin literal values.
module tb_fifo_ctrl;

    logic clk;
    logic rst;
    logic wr_req;
    logic rd_req;
    logic full;
    logic empty;

    int n_pass = 0;
    int n_chk  = 0;

    fifo_ctrl_if #(.CW(8)) bus8 ();
    fifo_ctrl_if #(.CW(2)) bus2 ();

    assign bus8.wr_req = wr_req;
    assign bus8.rd_req = rd_req;
    assign bus8.full   = full;
    assign bus8.empty  = empty;
    assign bus2.wr_req = wr_req;
    assign bus2.rd_req = rd_req;
    assign bus2.full   = full;
    assign bus2.empty  = empty;

    fifo_ctrl #(.CW(8)) dut   (.clk(clk), .rst(rst), .bus(bus8));
    fifo_ctrl #(.CW(2)) dut_s (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: {busy, ld1, ld2, ld3, wr_ack, rd_valid}
    localparam logic [5:0] A_IDLE = 6'b000000;
    localparam logic [5:0] A_BUSY = 6'b100000;
    localparam logic [5:0] A_LD1  = 6'b110000;
    localparam logic [5:0] A_WR   = 6'b101010;
    localparam logic [5:0] A_RD   = 6'b100100;
    localparam logic [5:0] A_RDV  = 6'b100001;

    logic [5:0] sched[$];
    logic [5:0] m_cur      = A_IDLE;
    bit         m_valid    = 1'b0;
    bit         m_last_rd  = 1'b1;
    bit         m_ovf      = 1'b0;
    bit         m_unf      = 1'b0;
    int         m_cnt      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an idle cycle looks at the requests; a granted
    // operation appends its future per-cycle output pattern to a schedule.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                sched.delete();
                m_cur     = A_LD1;
                m_last_rd = 1'b1;
                m_ovf     = 1'b0;
                m_unf     = 1'b0;
                m_cnt     = 0;
                m_valid   = 1'b1;
            end else if (m_valid) begin
                if (m_cur == A_IDLE) begin
                    bit w;
                    bit r;
                    if (wr_req && full)  begin m_ovf = 1'b1; m_cnt++; end
                    if (rd_req && empty) begin m_unf = 1'b1; m_cnt++; end
                    w = wr_req && !full;
                    r = rd_req && !empty;
                    if (w && r) begin
                        if (m_last_rd) w = 1'b1; else w = 1'b0;
                        r = !w;
                    end
                    if (w) begin
                        sched.push_back(A_WR);
                        m_last_rd = 1'b0;
                    end else if (r) begin
                        sched.push_back(A_RD);
                        sched.push_back(A_RDV);
                        m_last_rd = 1'b1;
                    end
                end
                m_cur = (sched.size() > 0) ? sched.pop_front() : A_IDLE;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                logic [5:0] exp_v;
                exp_v = rst ? A_BUSY : m_cur;
                chk("strobes8", int'({bus8.busy, bus8.ld1, bus8.ld2, bus8.ld3, bus8.wr_ack, bus8.rd_valid}), int'(exp_v));
                chk("strobes2", int'({bus2.busy, bus2.ld1, bus2.ld2, bus2.ld3, bus2.wr_ack, bus2.rd_valid}), int'(exp_v));
                chk("overflow", int'(bus8.overflow), int'(m_ovf));
                chk("underflow", int'(bus8.underflow), int'(m_unf));
                chk("drop_cnt8", int'(bus8.drop_cnt), (m_cnt > 255) ? 255 : m_cnt);
                chk("drop_cnt2", int'(bus2.drop_cnt), (m_cnt > 3) ? 3 : m_cnt);
                chk("flags2", int'({bus2.overflow, bus2.underflow}), int'({m_ovf, m_unf}));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        wr_req = 1'b0;
        rd_req = 1'b0;
        full   = 1'b0;
        empty  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        nxt();
        chk("rst_busy", int'(bus8.busy), 1);
        chk("rst_ld1", int'(bus8.ld1), 0);
        rst = 1'b0;
        #1;
        chk("init_ld1", int'(bus8.ld1), 1);
        nxt();
        chk("idle_busy", int'(bus8.busy), 0);
        chk("idle_ld1", int'(bus8.ld1), 0);
    endtask

    initial begin
        int acks;
        int ld2s;
        string order;
        int ld3_at;
        int rdv_at;

        rst = 1'b1;
        idle_inputs();

        // Release from reset: ld1 in cycle 1, idle in cycle 2.
        do_reset();

        // Write held three sampled cycles: two acknowledges with an idle gap.
        wr_req = 1'b1;
        acks = 0;
        ld2s = 0;
        repeat (3) begin
            nxt();
            acks += int'(bus8.wr_ack);
            ld2s += int'(bus8.ld2);
        end
        wr_req = 1'b0;
        repeat (2) begin
            nxt();
            acks += int'(bus8.wr_ack);
            ld2s += int'(bus8.ld2);
        end
        chk("wr_held_acks", acks, 2);
        chk("wr_held_ld2", ld2s, 2);

        // Both eligible from reset: write, read, write; rd_valid follows ld3.
        do_reset();
        wr_req = 1'b1;
        rd_req = 1'b1;
        order  = "";
        ld3_at = -1;
        rdv_at = -1;
        for (int i = 0; i < 8; i++) begin
            nxt();
            if (bus8.ld2) order = {order, "W"};
            if (bus8.ld3) begin
                order = {order, "R"};
                if (ld3_at < 0) ld3_at = i;
            end
            if (bus8.rd_valid && rdv_at < 0) rdv_at = i;
        end
        idle_inputs();
        chk("arb_order_0", int'(order.getc(0)), int'("W"));
        chk("arb_order_1", int'(order.getc(1)), int'("R"));
        chk("arb_order_2", int'(order.getc(2)), int'("W"));
        // READ cycle carries ld3; the RD_DONE cycle right after carries rd_valid.
        chk("rd_valid_after_ld3", rdv_at - ld3_at, 1);
        nxt();
        nxt();

        // Five refused writes while full, then served once full drops.
        do_reset();
        full   = 1'b1;
        wr_req = 1'b1;
        ld2s   = 0;
        repeat (5) begin
            nxt();
            ld2s += int'(bus8.ld2);
        end
        chk("ovf_ld2_never", ld2s, 0);
        chk("ovf_flag", int'(bus8.overflow), 1);
        chk("ovf_drop5", int'(bus8.drop_cnt), 5);
        chk("ovf_drop_sat2", int'(bus2.drop_cnt), 3);
        full = 1'b0;
        nxt();
        chk("ovf_then_ack", int'(bus8.wr_ack), 1);
        wr_req = 1'b0;
        nxt();

        // Both refused for three cycles: +2 each, CW=2 saturates at 3.
        do_reset();
        full   = 1'b1;
        empty  = 1'b1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        repeat (3) nxt();
        chk("both_drop_sat2", int'(bus2.drop_cnt), 3);
        chk("both_drop8", int'(bus8.drop_cnt), 6);
        chk("both_ovf", int'(bus2.overflow), 1);
        chk("both_unf", int'(bus2.underflow), 1);
        idle_inputs();
        nxt();

        // Reset during READ: no rd_valid, flags and counter cleared, INIT next.
        do_reset();
        empty  = 1'b1;
        rd_req = 1'b1;
        nxt();
        empty = 1'b0;
        nxt();
        chk("abort_ld3", int'(bus8.ld3), 1);
        chk("abort_unf_before", int'(bus8.underflow), 1);
        rst = 1'b1;
        #1;
        chk("abort_ld3_gated", int'(bus8.ld3), 0);
        nxt();
        chk("abort_no_rdv", int'(bus8.rd_valid), 0);
        chk("abort_unf_clr", int'(bus8.underflow), 0);
        chk("abort_drop_clr", int'(bus8.drop_cnt), 0);
        rd_req = 1'b0;
        rst    = 1'b0;
        #1;
        chk("abort_init", int'(bus8.ld1), 1);
        nxt();

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            wr_req = ($urandom_range(0, 99) < 60);
            rd_req = ($urandom_range(0, 99) < 60);
            full   = ($urandom_range(0, 99) < 25);
            empty  = ($urandom_range(0, 99) < 25);
            nxt();
        end
        rst = 1'b0;
        idle_inputs();
        nxt();
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
